// File: rtl/obi_burst_bridge_if.sv
// rtl/obi_burst_bridge_if.sv - OBI request/response bus between the burst bridge and gr_heep_top
interface obi_burst_bridge_if #(
  parameter int pADDR_WIDTH = 32,
  parameter int pDATA_WIDTH = 32
);
  logic                     req;
  logic                     we;
  logic [pDATA_WIDTH/8-1:0] be;
  logic [pADDR_WIDTH-1:0]   addr;
  logic [pDATA_WIDTH-1:0]   wdata;
  logic                     gnt;
  logic                     rvalid;
  logic [pDATA_WIDTH-1:0]   rdata;

  modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/obi_burst_bridge.sv
// rtl/obi_burst_bridge.sv - host command to OBI word-burst bridge with write/read FIFOs and credit-limited pipelining
module obi_burst_bridge #(
  parameter int pADDR_WIDTH = 32,
  parameter int pDATA_WIDTH = 32,
  parameter int pFIFO_DEPTH = 4,
  parameter int pMAX_OUTST  = 2,
  parameter int pLEN_WIDTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     set_addr_i,
  input  logic [pADDR_WIDTH-1:0]   set_addr_data_i,
  input  logic                     wr_valid_i,
  input  logic [pDATA_WIDTH-1:0]   wr_data_i,
  input  logic [pDATA_WIDTH/8-1:0] wr_be_i,
  output logic                     wr_ready_o,
  input  logic                     rd_req_i,
  input  logic [pLEN_WIDTH-1:0]    rd_len_i,
  output logic                     rd_valid_o,
  output logic [pDATA_WIDTH-1:0]   rd_data_o,
  input  logic                     rd_ready_i,
  output logic                     busy_o,
  output logic                     cmd_err_o,
  obi_burst_bridge_if.master       obi
);
  localparam int BE_W = pDATA_WIDTH / 8;
  localparam int PW   = $clog2(pFIFO_DEPTH);
  localparam int CW   = PW + 1;
  localparam logic [pADDR_WIDTH-1:0] STRIDE  = pADDR_WIDTH'(BE_W);
  localparam logic [CW-1:0]          DEPTH_C = CW'(pFIFO_DEPTH);
  localparam logic [CW-1:0]          MAX_C   = CW'(pMAX_OUTST);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN} state_t;

  state_t                 state;
  logic                   rd_mode;
  logic [pADDR_WIDTH-1:0] ptr;
  logic [pLEN_WIDTH-1:0]  beats;
  logic [CW-1:0]          outst;
  logic                   cmd_err;
  logic                   req_q, we_q;
  logic [BE_W-1:0]        be_q;
  logic [pADDR_WIDTH-1:0] addr_q;
  logic [pDATA_WIDTH-1:0] wdata_q;

  logic [CW-1:0]          wf_wp, wf_rp, rf_wp, rf_rp;
  logic [pDATA_WIDTH-1:0] wf_data [pFIFO_DEPTH];
  logic [BE_W-1:0]        wf_be   [pFIFO_DEPTH];
  logic [pDATA_WIDTH-1:0] rf_data [pFIFO_DEPTH];

  logic [CW-1:0]          wf_count, rf_count, wf_count_next, rf_count_next, outst_next, wf_after_pop;
  logic                   txn, wr_push, wr_pop, rd_grant, rsp_ok, rf_push, rf_pop;
  logic                   set_ok, rd_start, cmd_drop, slot_free, write_can, read_can;
  logic [pADDR_WIDTH-1:0] ptr_base, ptr_next;
  logic [pLEN_WIDTH-1:0]  beats_next;
  logic [PW-1:0]          head_idx;
  logic [pDATA_WIDTH-1:0] head_data;
  logic [BE_W-1:0]        head_be;

  assign wf_count   = wf_wp - wf_rp;
  assign rf_count   = rf_wp - rf_rp;
  assign busy_o     = (state != S_IDLE) || (outst != '0) || (wf_count != '0);
  assign wr_ready_o = (wf_count != DEPTH_C) && !(state == S_READ || (state == S_DRAIN && rd_mode));
  assign rd_valid_o = (rf_count != '0);
  assign rd_data_o  = rd_valid_o ? rf_data[rf_rp[PW-1:0]] : '0;
  assign cmd_err_o  = cmd_err;

  assign obi.req   = req_q;
  assign obi.we    = we_q;
  assign obi.be    = be_q;
  assign obi.addr  = addr_q;
  assign obi.wdata = wdata_q;

  assign txn      = req_q && obi.gnt;
  assign wr_push  = wr_valid_i && wr_ready_o;
  assign wr_pop   = txn && we_q;
  assign rd_grant = txn && !we_q;
  assign rsp_ok   = obi.rvalid && (outst != '0);
  assign rf_push  = rsp_ok && rd_mode;
  assign rf_pop   = rd_ready_i && rd_valid_o;

  assign outst_next    = outst + CW'(txn) - CW'(rsp_ok);
  assign wf_count_next = wf_count + CW'(wr_push) - CW'(wr_pop);
  assign rf_count_next = rf_count + CW'(rf_push) - CW'(rf_pop);
  assign beats_next    = beats - pLEN_WIDTH'(rd_grant);

  assign set_ok   = set_addr_i && !busy_o;
  assign rd_start = rd_req_i && !busy_o && (rd_len_i != '0);
  assign cmd_drop = (set_addr_i || rd_req_i) && busy_o;
  assign ptr_base = set_ok ? (set_addr_data_i & ~(STRIDE - pADDR_WIDTH'(1))) : ptr;
  assign ptr_next = ptr_base + (txn ? STRIDE : '0);

  // Next write beat comes from the FIFO, or straight from the host when it is being pushed into an empty FIFO
  assign wf_after_pop = wf_count - CW'(wr_pop);
  assign head_idx     = wf_rp[PW-1:0] + PW'(wr_pop);
  assign head_data    = (wf_after_pop == '0) ? wr_data_i : wf_data[head_idx];
  assign head_be      = (wf_after_pop == '0) ? wr_be_i   : wf_be[head_idx];

  assign slot_free = !req_q || txn;
  assign write_can = (wf_count_next != '0) && (outst_next < MAX_C);
  // Reads in flight plus buffered reads never exceed the read FIFO, so rvalid can always be stored
  assign read_can  = (({1'b0, rf_count_next} + {1'b0, outst_next}) < {1'b0, DEPTH_C}) && (outst_next < MAX_C);

  always_ff @(posedge clk) begin
    if (wr_push) begin
      wf_data[wf_wp[PW-1:0]] <= wr_data_i;
      wf_be[wf_wp[PW-1:0]]   <= wr_be_i;
    end
    if (rf_push) rf_data[rf_wp[PW-1:0]] <= obi.rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      rd_mode <= 1'b0;
      ptr     <= '0;
      beats   <= '0;
      outst   <= '0;
      cmd_err <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wf_wp   <= '0;
      wf_rp   <= '0;
      rf_wp   <= '0;
      rf_rp   <= '0;
    end else begin
      ptr   <= ptr_next;
      outst <= outst_next;
      wf_wp <= wf_wp + CW'(wr_push);
      wf_rp <= wf_rp + CW'(wr_pop);
      rf_wp <= rf_wp + CW'(rf_push);
      rf_rp <= rf_rp + CW'(rf_pop);
      if (cmd_drop || (obi.rvalid && outst == '0)) cmd_err <= 1'b1;
      if (txn) req_q <= 1'b0;

      case (state)
        S_IDLE: begin
          if (rd_start) begin
            state   <= S_READ;
            rd_mode <= 1'b1;
            beats   <= rd_len_i;
            if (read_can) begin
              req_q   <= 1'b1;
              we_q    <= 1'b0;
              be_q    <= '1;
              addr_q  <= ptr_next;
              wdata_q <= '0;
            end
          end else if (wf_count_next != '0) begin
            state   <= S_WRITE;
            rd_mode <= 1'b0;
            if (write_can) begin
              req_q   <= 1'b1;
              we_q    <= 1'b1;
              be_q    <= head_be;
              addr_q  <= ptr_next;
              wdata_q <= head_data;
            end
          end
        end
        S_WRITE: begin
          if (slot_free) begin
            if (write_can) begin
              req_q   <= 1'b1;
              we_q    <= 1'b1;
              be_q    <= head_be;
              addr_q  <= ptr_next;
              wdata_q <= head_data;
            end else if (wf_count_next == '0) begin
              state <= S_DRAIN;
            end
          end
        end
        S_READ: begin
          beats <= beats_next;
          if (rd_grant && beats == pLEN_WIDTH'(1)) begin
            state <= S_DRAIN;
          end else if (slot_free && beats_next != '0 && read_can) begin
            req_q   <= 1'b1;
            we_q    <= 1'b0;
            be_q    <= '1;
            addr_q  <= ptr_next;
            wdata_q <= '0;
          end
        end
        S_DRAIN: begin
          if (outst_next == '0) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_obi_burst_bridge.sv
// tb/tb_obi_burst_bridge.sv - directed self-checking bench for obi_burst_bridge with an OBI slave model
module tb_obi_burst_bridge;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        set_addr_i;
  logic [31:0] set_addr_data_i;
  logic        wr_valid_i;
  logic [31:0] wr_data_i;
  logic [3:0]  wr_be_i;
  logic        wr_ready_o;
  logic        rd_req_i;
  logic [7:0]  rd_len_i;
  logic        rd_valid_o;
  logic [31:0] rd_data_o;
  logic        rd_ready_i;
  logic        busy_o;
  logic        cmd_err_o;

  obi_burst_bridge_if #(.pADDR_WIDTH(32), .pDATA_WIDTH(32)) obi ();

  obi_burst_bridge #(
    .pADDR_WIDTH(32), .pDATA_WIDTH(32), .pFIFO_DEPTH(4), .pMAX_OUTST(2), .pLEN_WIDTH(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .set_addr_i(set_addr_i), .set_addr_data_i(set_addr_data_i),
    .wr_valid_i(wr_valid_i), .wr_data_i(wr_data_i), .wr_be_i(wr_be_i), .wr_ready_o(wr_ready_o),
    .rd_req_i(rd_req_i), .rd_len_i(rd_len_i),
    .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o), .rd_ready_i(rd_ready_i),
    .busy_o(busy_o), .cmd_err_o(cmd_err_o),
    .obi(obi)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Slave model: grants after gnt_delay waiting cycles, answers one cycle after grant when rsp_en
  int          gnt_delay;
  logic        rsp_en;
  int          req_wait = 0;
  int          rv_cnt = 0;
  int          cyc = 0;
  logic [31:0] pend_d [$];
  logic [31:0] t_addr [$];
  logic [31:0] t_wdata [$];
  logic        t_we [$];
  logic [3:0]  t_be [$];
  int          t_cyc [$];

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  always @(negedge clk) begin
    cyc++;
    obi.rvalid = 1'b0;
    obi.rdata  = '0;
    if (rsp_en && pend_d.size() > 0) begin
      obi.rvalid = 1'b1;
      obi.rdata  = pend_d.pop_front();
      rv_cnt++;
    end
    if (rst_n && obi.req && req_wait >= gnt_delay) begin
      obi.gnt = 1'b1;
      t_addr.push_back(obi.addr);
      t_wdata.push_back(obi.wdata);
      t_we.push_back(obi.we);
      t_be.push_back(obi.be);
      t_cyc.push_back(cyc);
      pend_d.push_back(obi.we ? 32'h0 : rd_model(obi.addr));
      req_wait = 0;
    end else begin
      obi.gnt = 1'b0;
      if (obi.req) req_wait++;
    end
  end

  int g_base = 0;
  int rv_base = 0;
  logic [31:0] words [$];

  function automatic int grants();
    return t_addr.size() - g_base;
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic new_test();
    g_base  = t_addr.size();
    rv_base = rv_cnt;
    words.delete();
  endtask

  task automatic wait_idle(input int max);
    for (int i = 0; i < max && busy_o; i++) step();
    chk("idle_reached", {31'b0, busy_o}, 32'h0);
  endtask

  task automatic set_addr(input logic [31:0] a);
    set_addr_i = 1'b1; set_addr_data_i = a;
    step();
    set_addr_i = 1'b0;
  endtask

  task automatic read_req(input logic [7:0] len);
    rd_req_i = 1'b1; rd_len_i = len;
    step();
    rd_req_i = 1'b0;
  endtask

  typedef struct {
    logic [31:0] base;
    int          len;
    int          dly;
    logic [31:0] first;
    logic [31:0] last;
  } rvec_t;

  rvec_t vt [4];

  initial begin
    vt[0] = '{base: 32'h0000_0100, len: 1, dly: 0, first: 32'h0000_0100, last: 32'h0000_0100};
    vt[1] = '{base: 32'h0000_0203, len: 3, dly: 1, first: 32'h0000_0200, last: 32'h0000_0208};
    vt[2] = '{base: 32'hFFFF_FFFC, len: 2, dly: 0, first: 32'hFFFF_FFFC, last: 32'h0000_0000};
    vt[3] = '{base: 32'h0000_0400, len: 0, dly: 0, first: 32'h0, last: 32'h0};

    rst_n = 1'b0; set_addr_i = 1'b0; set_addr_data_i = '0; wr_valid_i = 1'b0; wr_data_i = '0;
    wr_be_i = '0; rd_req_i = 1'b0; rd_len_i = '0; rd_ready_i = 1'b0; gnt_delay = 0; rsp_en = 1'b1;
    repeat (3) step();
    chk("rst_req", {31'b0, obi.req}, 32'h0);
    chk("rst_we", {31'b0, obi.we}, 32'h0);
    chk("rst_be", {28'b0, obi.be}, 32'h0);
    chk("rst_addr", obi.addr, 32'h0);
    chk("rst_wdata", obi.wdata, 32'h0);
    chk("rst_busy", {31'b0, busy_o}, 32'h0);
    chk("rst_cmd_err", {31'b0, cmd_err_o}, 32'h0);
    chk("rst_rd_valid", {31'b0, rd_valid_o}, 32'h0);
    chk("rst_rd_data", rd_data_o, 32'h0);
    rst_n = 1'b1;
    step();

    // Three-word write burst, grant always high
    new_test();
    set_addr(32'h0000_1000);
    for (int i = 0; i < 3; i++) begin
      wr_valid_i = 1'b1; wr_data_i = 32'h1111_0000 + i; wr_be_i = 4'hF;
      step();
      if (i == 0) begin
        chk("wr_latency_req", {31'b0, obi.req}, 32'h1);
        chk("wr_latency_addr", obi.addr, 32'h0000_1000);
      end
    end
    wr_valid_i = 1'b0;
    begin
      int last_busy_rv;
      last_busy_rv = -1;
      for (int i = 0; i < 30 && busy_o; i++) begin
        last_busy_rv = rv_cnt - rv_base;
        step();
      end
      chk("wr_idle", {31'b0, busy_o}, 32'h0);
      chk("wr_busy_until_3rd_rvalid", last_busy_rv, 32'd3);
    end
    chk("wr_grants", grants(), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("wr_addr", t_addr[g_base+i], 32'h0000_1000 + 32'(4*i));
      chk("wr_wdata", t_wdata[g_base+i], 32'h1111_0000 + i);
      chk("wr_we", {31'b0, t_we[g_base+i]}, 32'h1);
    end
    chk("wr_back_to_back", t_cyc[g_base+2] - t_cyc[g_base], 32'd2);

    // Six-word read with the host not popping: credit limit stops after four grants
    new_test();
    set_addr(32'h0000_2000);
    read_req(8'd6);
    repeat (12) step();
    chk("rd_stall_grants", grants(), 32'd4);
    chk("rd_stall_valid", {31'b0, rd_valid_o}, 32'h1);
    chk("rd_stall_busy", {31'b0, busy_o}, 32'h1);
    rd_ready_i = 1'b1;
    for (int i = 0; i < 40 && (busy_o || rd_valid_o); i++) begin
      if (rd_valid_o) words.push_back(rd_data_o);
      step();
    end
    chk("rd_words", words.size(), 32'd6);
    chk("rd_grants", grants(), 32'd6);
    for (int i = 0; i < words.size(); i++)
      chk("rd_data", words[i], rd_model(32'h0000_2000 + 32'(4*i)));
    chk("rd_last_addr", t_addr[g_base+5], 32'h0000_2014);

    // Delayed grant: request held stable
    new_test();
    gnt_delay = 3;
    set_addr(32'h0000_3000);
    wr_valid_i = 1'b1; wr_data_i = 32'hDEAD_BEEF; wr_be_i = 4'h3;
    step();
    wr_valid_i = 1'b0;
    begin
      int held, bad;
      held = 0; bad = 0;
      for (int i = 0; i < 10 && grants() == 0; i++) begin
        if (obi.req) begin
          held++;
          if (obi.addr !== 32'h0000_3000 || obi.wdata !== 32'hDEAD_BEEF || obi.be !== 4'h3) bad++;
        end
        step();
      end
      chk("hold_stable", bad, 32'd0);
      chk("hold_cycles", held, 32'd3);
    end
    chk("hold_grant_addr", t_addr[g_base], 32'h0000_3000);
    chk("hold_grant_be", {28'b0, t_be[g_base]}, 32'h3);
    wait_idle(30);
    gnt_delay = 0;

    // Table of read bursts including address wrap, forced alignment and zero length
    for (int v = 0; v < 4; v++) begin
      new_test();
      gnt_delay = vt[v].dly;
      set_addr(vt[v].base);
      read_req(8'(vt[v].len));
      rd_ready_i = 1'b1;
      for (int i = 0; i < 40; i++) begin
        if (i > 2 && !busy_o && !rd_valid_o) break;
        if (rd_valid_o) words.push_back(rd_data_o);
        step();
      end
      chk("tbl_grants", grants(), vt[v].len);
      chk("tbl_words", words.size(), vt[v].len);
      if (vt[v].len > 0 && grants() == vt[v].len) begin
        chk("tbl_first_addr", t_addr[g_base], vt[v].first);
        chk("tbl_last_addr", t_addr[g_base+vt[v].len-1], vt[v].last);
      end
      for (int i = 0; i < words.size(); i++)
        chk("tbl_data", words[i], rd_model(vt[v].first + 32'(4*i)));
      chk("tbl_no_err", {31'b0, cmd_err_o}, 32'h0);
    end
    gnt_delay = 0;

    // Commands while a write burst is active are dropped
    new_test();
    gnt_delay = 2;
    set_addr(32'h0000_4000);
    for (int i = 0; i < 2; i++) begin
      wr_valid_i = 1'b1; wr_data_i = 32'hABCD_0000 + i; wr_be_i = 4'hF;
      step();
    end
    wr_valid_i = 1'b0;
    set_addr(32'h0000_9000);
    read_req(8'd3);
    chk("drop_cmd_err", {31'b0, cmd_err_o}, 32'h1);
    wait_idle(40);
    chk("drop_grants", grants(), 32'd2);
    for (int i = 0; i < 2; i++) begin
      chk("drop_addr", t_addr[g_base+i], 32'h0000_4000 + 32'(4*i));
      chk("drop_we", {31'b0, t_we[g_base+i]}, 32'h1);
      chk("drop_wdata", t_wdata[g_base+i], 32'hABCD_0000 + i);
    end
    chk("drop_no_read", {31'b0, rd_valid_o}, 32'h0);
    gnt_delay = 0;

    // Reset with two reads outstanding, then late responses arrive
    new_test();
    rsp_en = 1'b0;
    rd_ready_i = 1'b0;
    set_addr(32'h0000_5000);
    read_req(8'd4);
    for (int i = 0; i < 10 && grants() < 2; i++) step();
    repeat (2) step();
    chk("rst_mid_grants", grants(), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_req", {31'b0, obi.req}, 32'h0);
    chk("rst_mid_addr", obi.addr, 32'h0);
    chk("rst_mid_busy", {31'b0, busy_o}, 32'h0);
    chk("rst_mid_cmd_err", {31'b0, cmd_err_o}, 32'h0);
    chk("rst_mid_rd_valid", {31'b0, rd_valid_o}, 32'h0);
    step();
    rst_n = 1'b1;
    rsp_en = 1'b1;
    repeat (5) step();
    chk("late_rvalids_seen", rv_cnt - rv_base, 32'd2);
    chk("late_rd_valid", {31'b0, rd_valid_o}, 32'h0);
    chk("late_busy", {31'b0, busy_o}, 32'h0);
    chk("late_cmd_err", {31'b0, cmd_err_o}, 32'h1);
    chk("late_no_grants", grants(), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
